// File: rtl/imem_loader_if.sv
// Byte-serial load channel for the instruction memory loader.
// The master drives bytes and the loader (slave) answers with byte_ready.
interface imem_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Writable 32x16 instruction memory for the single-cycle datapath.
// Loaded as big-endian byte pairs followed by one XOR checksum byte.
module imem_loader #(
  parameter int WIDTH = 16,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] q,
  input  logic             load_start,
  input  logic [AW:0]      load_len,
  imem_loader_if.slave     bus,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             chk_err,
  output logic [AW:0]      word_count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_W    = {{AW{1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GET_HI  = 3'd1;
  localparam logic [2:0] S_GET_LO  = 3'd2;
  localparam logic [2:0] S_GET_CHK = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    hi_q, hi_d;
  logic          err_q, err_d;

  // Power-up contents are zero; reset deliberately leaves the image intact.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic xfer;
  logic we;

  assign bus.byte_ready = (state_q == S_GET_HI) || (state_q == S_GET_LO) ||
                          (state_q == S_GET_CHK);
  assign xfer       = bus.byte_valid && bus.byte_ready;
  assign we         = (state_q == S_GET_LO) && xfer;
  assign cpu_hold   = (state_q != S_IDLE);
  assign load_done  = (state_q == S_FINISH);
  assign chk_err    = err_q;
  assign word_count = cnt_q;
  assign q          = mem[addr];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          len_d   = (load_len == '0) ? FULL_LEN : load_len;
          wptr_d  = '0;
          cnt_d   = '0;
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = S_GET_HI;
        end
      end
      S_GET_HI: begin
        if (xfer) begin
          hi_d    = bus.byte_in;
          acc_d   = acc_q ^ bus.byte_in;
          state_d = S_GET_LO;
        end
      end
      S_GET_LO: begin
        if (xfer) begin
          acc_d   = acc_q ^ bus.byte_in;
          wptr_d  = wptr_q + 1'b1;
          cnt_d   = cnt_q + ONE_W;
          state_d = ((cnt_q + ONE_W) == len_q) ? S_GET_CHK : S_GET_HI;
        end
      end
      S_GET_CHK: begin
        if (xfer) begin
          err_d   = (bus.byte_in != acc_q);
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  // A reset edge abandons the session, including a low byte arriving on it.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[wptr_q] <= {hi_q, bus.byte_in};
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: power-up image, loads, checksum error,
// random valid gaps, mid-session reset and ignored load_start.
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] addr;
  logic [15:0] q;
  logic       load_start;
  logic [5:0] load_len;
  logic       cpu_hold;
  logic       load_done;
  logic       chk_err;
  logic [5:0] word_count;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int rdy_viol = 0;

  always #5 clk = ~clk;

  imem_loader_if bif();

  imem_loader #(.WIDTH(16), .AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .q          (q),
    .load_start (load_start),
    .load_len   (load_len),
    .bus        (bif),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .chk_err    (chk_err),
    .word_count (word_count)
  );

  always @(negedge clk) begin
    if (load_done) done_cnt++;
    if (bif.byte_ready && (!cpu_hold || load_done)) rdy_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int budget;
    bif.byte_in    = b;
    bif.byte_valid = 1'b1;
    budget = 0;
    while (!bif.byte_ready && budget < 50) begin
      step();
      budget++;
    end
    if (budget >= 50) check("rdy_wait", 32'(bif.byte_ready), 32'd1);
    else step();
  endtask

  task automatic start(input logic [5:0] len);
    load_start = 1'b1;
    load_len   = len;
    step();
    load_start = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int a, input logic [15:0] exp);
    addr = a[4:0];
    step();
    check(tag, 32'(q), 32'(exp));
  endtask

  initial begin
    logic [7:0] acc;
    logic [7:0] hi;
    logic [7:0] lo;
    int d0;

    reset = 1'b1;
    load_start = 1'b0;
    load_len = '0;
    addr = '0;
    bif.byte_in = '0;
    bif.byte_valid = 1'b0;
    step();
    step();
    check("rst_ready", 32'(bif.byte_ready), 32'd0);
    check("rst_hold",  32'(cpu_hold), 32'd0);
    check("rst_done",  32'(load_done), 32'd0);
    check("rst_err",   32'(chk_err), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) read_chk("pwr_zero", i, 16'h0000);

    // Two-word load, good checksum
    start(6'd2);
    check("t1_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h40);
    bif.byte_valid = 1'b0;
    check("t1_done",     32'(load_done), 32'd1);
    check("t1_fin_rdy",  32'(bif.byte_ready), 32'd0);
    step();
    check("t1_done_end", 32'(load_done), 32'd0);
    check("t1_hold_end", 32'(cpu_hold), 32'd0);
    check("t1_err",      32'(chk_err), 32'd0);
    check("t1_wc",       32'(word_count), 32'd2);
    read_chk("t1_mem0", 0, 16'h1234);
    read_chk("t1_mem1", 1, 16'hABCD);

    // Same image, bad checksum
    start(6'd2);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h41);
    bif.byte_valid = 1'b0;
    step();
    check("t2_err", 32'(chk_err), 32'd1);
    read_chk("t2_mem0", 0, 16'h1234);
    read_chk("t2_mem1", 1, 16'hABCD);

    // Full 32-word load via len=0 with random valid gaps
    start(6'd0);
    check("t4_err_clr", 32'(chk_err), 32'd0);
    acc = 8'h00;
    for (int i = 0; i < 32; i++) begin
      hi = 8'(i);
      lo = ~hi;
      acc = acc ^ hi ^ lo;
      if ($urandom_range(0, 1) == 1) begin bif.byte_valid = 1'b0; step(); end
      send_byte(hi);
      if ($urandom_range(0, 1) == 1) begin bif.byte_valid = 1'b0; step(); end
      send_byte(lo);
    end
    send_byte(acc);
    bif.byte_valid = 1'b0;
    check("t4_done", 32'(load_done), 32'd1);
    step();
    check("t4_wc",  32'(word_count), 32'd32);
    check("t4_err", 32'(chk_err), 32'd0);
    for (int i = 0; i < 32; i++) begin
      hi = 8'(i);
      read_chk("t4_mem", i, {hi, ~hi});
    end
    check("t4_rdy_idle", 32'(rdy_viol), 32'd0);

    // Reset after three bytes of a four-word session
    d0 = done_cnt;
    start(6'd4);
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h77);
    bif.byte_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_hold", 32'(cpu_hold), 32'd0);
    check("t5_rdy",  32'(bif.byte_ready), 32'd0);
    check("t5_done", 32'(load_done), 32'd0);
    check("t5_wc",   32'(word_count), 32'd0);
    step();
    step();
    check("t5_no_done", 32'(done_cnt), 32'(d0));
    read_chk("t5_mem0", 0, 16'hA55A);
    read_chk("t5_mem1", 1, 16'h01FE);

    // load_start during GET_LO must be ignored
    start(6'd3);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    load_start = 1'b1;
    load_len = 6'd1;
    send_byte(8'h40);
    load_start = 1'b0;
    check("t6_wc2",  32'(word_count), 32'd2);
    check("t6_hold", 32'(cpu_hold), 32'd1);
    check("t6_rdy",  32'(bif.byte_ready), 32'd1);
    send_byte(8'h50); send_byte(8'h60);
    bif.byte_valid = 1'b0;
    check("t6_wc3",     32'(word_count), 32'd3);
    check("t6_chk_rdy", 32'(bif.byte_ready), 32'd1);
    check("t6_no_done", 32'(load_done), 32'd0);
    send_byte(8'h70);
    bif.byte_valid = 1'b0;
    check("t6_done", 32'(load_done), 32'd1);
    step();
    check("t6_err",      32'(chk_err), 32'd0);
    check("t6_hold_end", 32'(cpu_hold), 32'd0);
    read_chk("t6_mem0", 0, 16'h1020);
    read_chk("t6_mem1", 1, 16'h3040);
    read_chk("t6_mem2", 2, 16'h5060);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
